// File: rtl/exe_result_fifo_if.sv
// Handshake and status bundle between exe_result_fifo and its producer/consumer.
// out_par exists only when EXE_RESULT_FIFO_PARITY_EN is defined.
interface exe_result_fifo_if #(
  parameter int N     = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          in_valid;
  logic [N-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [N-1:0]  out_data;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          ovf;
  logic          ovf_clr;
`ifdef EXE_RESULT_FIFO_PARITY_EN
  logic          out_par;

  modport master (
    output in_valid, in_data, out_ready, ovf_clr,
    input  in_ready, out_valid, out_data, count, full, empty, ovf, out_par
  );
  modport slave (
    input  in_valid, in_data, out_ready, ovf_clr,
    output in_ready, out_valid, out_data, count, full, empty, ovf, out_par
  );
`else
  modport master (
    output in_valid, in_data, out_ready, ovf_clr,
    input  in_ready, out_valid, out_data, count, full, empty, ovf
  );
  modport slave (
    input  in_valid, in_data, out_ready, ovf_clr,
    output in_ready, out_valid, out_data, count, full, empty, ovf
  );
`endif
endinterface

// File: rtl/exe_result_fifo.sv
// First-word-fall-through result FIFO behind the execution-unit mux, with sticky overflow.
// Define EXE_RESULT_FIFO_PARITY_EN to store an even-parity bit per entry and drive out_par.
module exe_result_fifo #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                pclk,
  input  logic                presetn,
  exe_result_fifo_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
`ifdef EXE_RESULT_FIFO_PARITY_EN
  localparam int W = N + 1;
`else
  localparam int W = N;
`endif

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          ovf_reg, ovf_next;
  logic          full, empty, push, pop;
  logic [W-1:0]  wr_word, head_word;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

  // in_ready depends on registered occupancy only, so a same-cycle pop never admits a push.
  assign push = bus.in_valid && !full;
  assign pop  = bus.out_ready && !empty;

`ifdef EXE_RESULT_FIFO_PARITY_EN
  assign wr_word = {^bus.in_data, bus.in_data};
`else
  assign wr_word = bus.in_data;
`endif

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    ovf_next    = ovf_reg;
    if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
    if (push && !pop)      count_next = count_reg + CW'(1);
    else if (pop && !push) count_next = count_reg - CW'(1);
    // A fresh overflow outranks a clear in the same cycle.
    if (bus.in_valid && full) ovf_next = 1'b1;
    else if (bus.ovf_clr)     ovf_next = 1'b0;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      ovf_reg    <= ovf_next;
    end
  end

  // Storage is not reset; stale contents are never visible because empty gates out_valid.
  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr_reg] <= wr_word;
  end

  assign head_word     = mem[rd_ptr_reg];
  assign bus.out_data  = head_word[N-1:0];
  assign bus.out_valid = !empty;
  assign bus.in_ready  = !full;
  assign bus.count     = count_reg;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.ovf       = ovf_reg;
`ifdef EXE_RESULT_FIFO_PARITY_EN
  assign bus.out_par   = empty ? 1'b0 : head_word[W-1];
`endif
endmodule

// File: tb/tb_exe_result_fifo.sv
// Scoreboard bench for exe_result_fifo: stimulus pushes expected results, a negedge monitor checks them.
module tb_exe_result_fifo;
  localparam int N     = 8;
  localparam int DEPTH = 4;

  logic pclk;
  logic presetn;

  exe_result_fifo_if #(.N(N), .DEPTH(DEPTH)) bus ();

  exe_result_fifo #(.N(N), .DEPTH(DEPTH)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Reference model: occupancy and overflow flag plus queue of expected results.
  logic [N-1:0] exp_q[$];
  int           m_cnt = 0;
  bit           m_ovf = 1'b0;
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit v, input logic [N-1:0] d, input bit r, input bit c);
    int  old;
    bit  push, pop;
    old  = m_cnt;
    push = v && (old < DEPTH);
    pop  = r && (old > 0);
    if (push) exp_q.push_back(d);
    m_cnt = old + int'(push) - int'(pop);
    if (v && old == DEPTH) m_ovf = 1'b1;
    else if (c)            m_ovf = 1'b0;
  endtask

  // One cycle: drive inputs, let the edge happen, advance the model.
  task automatic step(input bit v, input logic [N-1:0] d, input bit r, input bit c);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    bus.ovf_clr   = c;
    @(posedge pclk);
    if (presetn) model_edge(v, d, r, c);
    #1;
  endtask

  always @(negedge pclk) begin
    chk("count",     int'(bus.count),     m_cnt);
    chk("full",      int'(bus.full),      int'(m_cnt == DEPTH));
    chk("empty",     int'(bus.empty),     int'(m_cnt == 0));
    chk("in_ready",  int'(bus.in_ready),  int'(m_cnt != DEPTH));
    chk("out_valid", int'(bus.out_valid), int'(m_cnt != 0));
    chk("ovf",       int'(bus.ovf),       int'(m_ovf));
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_data: got %0h expected nothing (scoreboard empty) at %0t", bus.out_data, $time);
      end else begin
        chk("out_data", int'(bus.out_data), int'(exp_q[0]));
`ifdef EXE_RESULT_FIFO_PARITY_EN
        chk("out_par", int'(bus.out_par), int'(^exp_q[0]));
`endif
        if (bus.out_ready && presetn) void'(exp_q.pop_front());
      end
    end
`ifdef EXE_RESULT_FIFO_PARITY_EN
    else chk("out_par_empty", int'(bus.out_par), 0);
`endif
  end

  initial begin
    logic [N-1:0] fill [4];
    fill[0] = 8'hAA; fill[1] = 8'hCC; fill[2] = 8'hF0; fill[3] = 8'h0F;

    presetn       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.ovf_clr   = 1'b0;
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b1;

    // Idle after reset.
    repeat (2) step(0, '0, 0, 0);

    // Fill to full, then drain in order.
    for (int i = 0; i < 4; i++) step(1, fill[i], 0, 0);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
    step(0, '0, 0, 0);

    // Steady push+pop at count 2; pointers wrap.
    step(1, 8'hE1, 0, 0);
    step(1, 8'hE2, 0, 0);
    for (int i = 1; i <= 6; i++) step(1, N'(i), 1, 0);
    repeat (2) step(0, '0, 1, 0);

    // Overflow: dropped data, clear, and set-beats-clear.
    for (int i = 0; i < 4; i++) step(1, N'($urandom_range(0, 255)), 0, 0);
    step(1, 8'h55, 0, 0);
    step(0, '0, 0, 1);
    step(1, 8'h66, 0, 1);
    step(1, 8'h77, 1, 0);
    repeat (4) step(0, '0, 1, 0);
    step(0, '0, 0, 1);

    // Asynchronous reset mid-stream.
    step(1, 8'h3C, 0, 0);
    step(1, 8'h81, 0, 0);
    #2 presetn = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    #1;
    chk("rst_count",     int'(bus.count),     0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready",  int'(bus.in_ready),  1);
    @(posedge pclk);
    #1 presetn = 1'b1;
    step(1, 8'h12, 0, 0);
    step(0, '0, 1, 0);

    // Parity-visible pair (checked by the monitor when parity is built in).
    step(1, 8'h07, 0, 0);
    step(1, 8'h03, 0, 0);
    repeat (2) step(0, '0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, N'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0);
    repeat (DEPTH + 1) step(0, '0, 1, 0);
    step(0, '0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/exe_result_fifo.md
# exe_result_fifo

Result buffer directly downstream of the execution unit's `mux_4to1` result select. It captures each selected N-bit result on a valid/ready push handshake, stores up to DEPTH results in order, and presents them first-word-fall-through to the APB read-side logic. Occupancy and a sticky overflow flag are exported for the APB status register.

## Interface
- `N`, default 8: result width; matches the mux width.
- `DEPTH`, default 4: number of entries; power of two, ≥2.
- `pclk  in  1`: clock; all state updates on its rising edge.
- `presetn  in  1`: asynchronous, active-low reset.
- `in_valid  in  1`: mux output holds a result to store.
- `in_data  in  N`: result from the mux `out`.
- `in_ready  out  1`: FIFO can accept; equals `!full`, registered state only.
- `out_valid  out  1`: head entry available; equals `!empty`.
- `out_data  out  N`: head entry, valid while `out_valid`=1.
- `out_ready  in  1`: consumer takes the head entry this cycle.
- `count  out  $clog2(DEPTH+1)`: occupancy, 0..DEPTH.
- `full  out  1`: `count==DEPTH`.
- `empty  out  1`: `count==0`.
- `ovf  out  1`: sticky; a push was attempted while full.
- `ovf_clr  in  1`: clears `ovf`.
- `out_par  out  1`: present only with `EXE_RESULT_FIFO_PARITY_EN`; see Configuration.

## Operation
- Push = `in_valid && in_ready`: write `in_data` at `wr_ptr`, `wr_ptr` increments modulo DEPTH.
- Pop = `out_valid && out_ready`: `rd_ptr` increments modulo DEPTH.
- `out_data` = `mem[rd_ptr]`, combinational from storage (first-word-fall-through). Value is don't-care when empty; the bench checks it only when `out_valid`=1.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. `count` is a separate register: +1 on push only, −1 on pop only, unchanged on both or neither.
- Simultaneous push and pop, 0<count<DEPTH: both occur, count unchanged, order preserved.
- Push when full: `in_ready`=0, so no write. If `in_valid`=1, `ovf` sets on that edge and the data is dropped. A pop in the same cycle does not admit the push, because `in_ready` has no combinational path from `out_ready`.
- Pop when empty: ignored, because `out_valid`=0.
- `ovf_clr` and a new overflow event in the same cycle: the set wins, and `ovf` stays 1.
- Reset (any time, including mid-stream): pointers=0, `count`=0, `ovf`=0. Contents are lost; storage need not be reset.
- Reset values: `in_ready`=1, `out_valid`=0, `full`=0, `empty`=1, `count`=0, `ovf`=0, `out_par`=0.

## Timing
- Push at edge k: entry is visible at `out_data` with `out_valid`=1 after edge k. Latency is 1 cycle.
- Throughput is 1 push and 1 pop per cycle.
- `full`, `empty`, `in_ready`, `out_valid` and `count` all update on the same edge as the pointer change.
- `presetn` assertion clears state immediately, without waiting for `pclk`. Deassertion is synchronised externally.

## Configuration
- `EXE_RESULT_FIFO_PARITY_EN` defined:
  - Each entry stores an extra bit `^in_data` (even parity), computed at push time.
  - `out_par` outputs the stored bit of the head entry; it is 0 when empty.
  - Storage width becomes N+1.
- `EXE_RESULT_FIFO_PARITY_EN` undefined:
  - No `out_par` port.
  - Storage is N bits.
  - All other behaviour is identical.

## Test plan
- Reset, then hold idle → `empty`=1, `in_ready`=1, `count`=0, `ovf`=0.
- Push 8'hAA, 8'hCC, 8'hF0, 8'h0F (one per cycle, `out_ready`=0) → `full`=1, `count`=4, `in_ready`=0. Then pop 4 → outputs appear in order AA, CC, F0, 0F, and `empty`=1 after the 4th pop.
- With `count`=2, drive push and pop together for 6 cycles with values 8'h01..8'h06 → `count` stays 2, popped order matches push order, and the pointers wrap past DEPTH.
- Fill to full, then push 8'h55 → `ovf`=1 and 8'h55 never appears. Assert `ovf_clr` with no push → `ovf`=0. Assert `ovf_clr` together with a blocked push → `ovf`=1.
- Push 8'h3C and 8'h81, then assert `presetn`=0 mid-cycle → `count`=0 and `out_valid`=0 immediately. After release, push 8'h12 → `out_data`=8'h12.
- With `EXE_RESULT_FIFO_PARITY_EN`: push 8'h07 then 8'h03 → `out_par`=1 for 8'h07, then `out_par`=0 for 8'h03 after the pop.
